// File: rtl/alu_issue_ctrl.sv
// Initiator-side ALU issue controller: accepts R-type commands, drives the ALU, returns its result.
// Optional macro ALU_ILLEGAL_TRAP_EN: unsupported funct answered at once with rsp_illegal, ALU untouched.
module alu_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES  = 1,
   parameter logic [3:0]  ILLEGAL_OPCODE = 4'b1111,
   localparam int unsigned DATA_W  = 32,
   localparam int unsigned FUNCT_W = 6,
   localparam int unsigned OP_W    = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [FUNCT_W-1:0] cmd_funct,
   input  logic [DATA_W-1:0]  cmd_rs,
   input  logic [DATA_W-1:0]  cmd_rt,
   output logic [DATA_W-1:0]  alu_rs,
   output logic [DATA_W-1:0]  alu_rt,
   output logic [OP_W-1:0]    alu_opcode,
   input  logic [DATA_W-1:0]  alu_data_out,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_zero,
   output logic               rsp_illegal,
   output logic               busy
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FUNCT_MUL = 6'h18;
   localparam logic [OP_W-1:0]    OP_ADD    = 4'b0000;
   localparam logic [OP_W-1:0]    OP_SUB    = 4'b0001;
   localparam logic [OP_W-1:0]    OP_MUL    = 4'b0010;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   alu_rs_q, alu_rs_d, alu_rt_q, alu_rt_d;
   logic [OP_W-1:0]     alu_op_q, alu_op_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                busy_q, busy_d;
   logic [OP_W-1:0]     dec_op_c;
   logic                accept_c;
   logic                trap_c;

   // funct -> ALU opcode
   always_comb begin
      dec_op_c = ILLEGAL_OPCODE;
      case (cmd_funct)
         FUNCT_ADD: dec_op_c = OP_ADD;
         FUNCT_SUB: dec_op_c = OP_SUB;
         FUNCT_MUL: dec_op_c = OP_MUL;
         default:   dec_op_c = ILLEGAL_OPCODE;
      endcase
   end

   assign accept_c = cmd_valid && (state_q == S_IDLE);

`ifdef ALU_ILLEGAL_TRAP_EN
   logic rsp_ill_q, rsp_ill_d;

   assign trap_c = accept_c && (cmd_funct != FUNCT_ADD) && (cmd_funct != FUNCT_SUB)
                   && (cmd_funct != FUNCT_MUL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rsp_ill_q <= 1'b0;
      else          rsp_ill_q <= rsp_ill_d;
   end

   // Flag follows the response payload: set on a trap, cleared on any ALU capture
   always_comb begin
      rsp_ill_d = rsp_ill_q;
      if (trap_c)                                      rsp_ill_d = 1'b1;
      else if ((state_q == S_EXEC) && (cnt_q == '0))   rsp_ill_d = 1'b0;
   end

   assign rsp_illegal = rsp_ill_q;
`else
   assign trap_c      = 1'b0;
   assign rsp_illegal = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         alu_rs_q    <= '0;
         alu_rt_q    <= '0;
         alu_op_q    <= ILLEGAL_OPCODE;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_rs_q    <= alu_rs_d;
         alu_rt_q    <= alu_rt_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (trap_c)        state_d = S_RESP;
            else if (accept_c) state_d = S_EXEC;
         end
         S_EXEC:  if (cnt_q == '0) state_d = S_RESP;
         S_RESP:  if (rsp_ready)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values; ALU operands change only on a non-trapped accept
   always_comb begin
      cnt_d       = cnt_q;
      alu_rs_d    = alu_rs_q;
      alu_rt_d    = alu_rt_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (trap_c) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_zero_d  = 1'b0;
            end else if (accept_c) begin
               alu_rs_d = cmd_rs;
               alu_rt_d = cmd_rt;
               alu_op_d = dec_op_c;
               cnt_d    = CNT_LOAD;
            end
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_data_d  = alu_data_out;
               rsp_zero_d  = (alu_op_q == OP_SUB) && alu_zero;
               rsp_valid_d = 1'b1;
            end
         end
         S_RESP:  if (rsp_ready) rsp_valid_d = 1'b0;
         default: ;
      endcase
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign alu_rs     = alu_rs_q;
   assign alu_rt     = alu_rt_q;
   assign alu_opcode = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: SETTLE_CYCLES=1 instance on a vector table + scoreboard,
// SETTLE_CYCLES=3 instance for back-pressure; also mid-operation reset sequences.
module tb_alu_issue_ctrl;

   localparam logic [3:0] ILL = 4'b1111;
`ifdef ALU_ILLEGAL_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        c1_valid, c1_ready, r1_valid, r1_ready, r1_zero, r1_ill, busy1, a1_zero;
   logic [5:0]  c1_funct;
   logic [31:0] c1_rs, c1_rt, a1_rs, a1_rt, a1_out, r1_data;
   logic [3:0]  a1_op;
   logic        c3_valid, c3_ready, r3_valid, r3_ready, r3_zero, r3_ill, busy3, a3_zero;
   logic [5:0]  c3_funct;
   logic [31:0] c3_rs, c3_rt, a3_rs, a3_rt, a3_out, r3_data;
   logic [3:0]  a3_op;

   // Reference ALU: combinational, zero flag raw (controller masks it)
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return p[31:0];
         default: return 32'd0;
      endcase
   endfunction

   assign a1_out  = alu_f(a1_op, a1_rs, a1_rt);
   assign a1_zero = (a1_out == 32'd0);
   assign a3_out  = alu_f(a3_op, a3_rs, a3_rt);
   assign a3_zero = (a3_out == 32'd0);

   alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
      .cmd_funct(c1_funct), .cmd_rs(c1_rs), .cmd_rt(c1_rt),
      .alu_rs(a1_rs), .alu_rt(a1_rt), .alu_opcode(a1_op),
      .alu_data_out(a1_out), .alu_zero(a1_zero),
      .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data(r1_data),
      .rsp_zero(r1_zero), .rsp_illegal(r1_ill), .busy(busy1));

   alu_issue_ctrl #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .reset_n(rst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
      .cmd_funct(c3_funct), .cmd_rs(c3_rs), .cmd_rt(c3_rt),
      .alu_rs(a3_rs), .alu_rt(a3_rt), .alu_opcode(a3_op),
      .alu_data_out(a3_out), .alu_zero(a3_zero),
      .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_data(r3_data),
      .rsp_zero(r3_zero), .rsp_illegal(r3_ill), .busy(busy3));

   typedef struct {
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [3:0]  op;
      logic [31:0] data;
      logic        zero;
      logic        ill;
   } vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic        zero;
      logic        ill;
   } exp_t;

   int   checks = 0;
   int   fails  = 0;
   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Response monitor for the SETTLE_CYCLES=1 instance
   always @(negedge clk) begin
      if (rst_n && r1_valid && r1_ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp: actual data=%0h expected no response", r1_data);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_data", r1_data, mon_e.data);
            chk("rsp_zero", 32'(r1_zero), 32'(mon_e.zero));
            chk("rsp_illegal", 32'(r1_ill), 32'(mon_e.ill));
         end
      end
   end

   // Present a command, wait for the accept edge, then scramble inputs
   task automatic send1(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      int n;
      n = 0;
      @(negedge clk);
      c1_funct = f; c1_rs = rs; c1_rt = rt; c1_valid = 1'b1;
      while (!c1_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      c1_valid = 1'b0;
      c1_funct = 6'($urandom);
      c1_rs    = $urandom;
      c1_rt    = $urandom;
   endtask

   task automatic wait_valid1(output int lat);
      lat = 0;
      while (!r1_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[11];
      logic [3:0]  prev_op;
      logic [31:0] prev_rs, prev_rt;
      logic [3:0]  e_op;
      logic [31:0] e_rs, e_rt;
      logic        trapped;
      int          lat;

      vecs[0]  = '{6'h20, 32'd5,         32'd7,         4'h0, 32'd12,        1'b0, 1'b0};
      vecs[1]  = '{6'h22, 32'h1234,      32'h1234,      4'h1, 32'd0,         1'b1, 1'b0};
      vecs[2]  = '{6'h22, 32'd9,         32'd4,         4'h1, 32'd5,         1'b0, 1'b0};
      vecs[3]  = '{6'h18, 32'h10000,     32'h10000,     4'h2, 32'd0,         1'b0, 1'b0};
      vecs[4]  = '{6'h18, 32'd6,         32'd7,         4'h2, 32'd42,        1'b0, 1'b0};
      vecs[5]  = '{6'h20, 32'hFFFF_FFFF, 32'd1,         4'h0, 32'd0,         1'b0, 1'b0};
      vecs[6]  = '{6'h22, 32'd0,         32'd1,         4'h1, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[7]  = '{6'h25, 32'd3,         32'd4,         ILL,  32'd0,         1'b0, TRAP};
      vecs[8]  = '{6'h00, 32'd8,         32'd8,         ILL,  32'd0,         1'b0, TRAP};
      vecs[9]  = '{6'h20, 32'h8000_0000, 32'h8000_0000, 4'h0, 32'd0,         1'b0, 1'b0};
      vecs[10] = '{6'h22, 32'd1,         32'd1,         4'h1, 32'd0,         1'b1, 1'b0};

      c1_valid = 1'b0; c1_funct = 6'h0; c1_rs = '0; c1_rt = '0; r1_ready = 1'b1;
      c3_valid = 1'b0; c3_funct = 6'h0; c3_rs = '0; c3_rt = '0; r3_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(c1_ready), 32'd1);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_rsp_valid", 32'(r1_valid), 32'd0);
      chk("rst_rsp_data", r1_data, 32'd0);
      chk("rst_rsp_zero", 32'(r1_zero), 32'd0);
      chk("rst_rsp_illegal", 32'(r1_ill), 32'd0);
      chk("rst_alu_opcode", 32'(a1_op), 32'(ILL));
      chk("rst_alu_rs", a1_rs, 32'd0);
      chk("rst_alu_rt", a1_rt, 32'd0);
      chk("rst3_alu_opcode", 32'(a3_op), 32'(ILL));
      @(negedge clk);
      rst_n = 1'b1;

      // Table of single commands, SETTLE_CYCLES=1, rsp_ready held high
      prev_op = ILL; prev_rs = '0; prev_rt = '0;
      for (int i = 0; i < 11; i++) begin
         trapped = TRAP && (vecs[i].op == ILL);
         e_op = trapped ? prev_op : vecs[i].op;
         e_rs = trapped ? prev_rs : vecs[i].rs;
         e_rt = trapped ? prev_rt : vecs[i].rt;
         sb.push_back('{vecs[i].data, vecs[i].zero, vecs[i].ill});
         send1(vecs[i].funct, vecs[i].rs, vecs[i].rt);
         chk($sformatf("v%0d_alu_opcode", i), 32'(a1_op), 32'(e_op));
         chk($sformatf("v%0d_alu_rs", i), a1_rs, e_rs);
         chk($sformatf("v%0d_alu_rt", i), a1_rt, e_rt);
         wait_valid1(lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), trapped ? 32'd0 : 32'd1);
         chk($sformatf("v%0d_alu_rs_hold", i), a1_rs, e_rs);
         prev_op = e_op; prev_rs = e_rs; prev_rt = e_rt;
      end

      // SETTLE_CYCLES=3 with back-pressure and cmd_valid held high throughout
      @(negedge clk);
      c3_funct = 6'h20; c3_rs = 32'd100; c3_rt = 32'd23; c3_valid = 1'b1; r3_ready = 1'b0;
      chk("s3_ready_idle", 32'(c3_ready), 32'd1);
      @(posedge clk);
      #1;
      c3_rs = 32'd999; c3_rt = 32'd1; c3_funct = 6'h22;
      lat = 0;
      while (!r3_valid && lat < 50) begin
         chk("s3_ready_exec", 32'(c3_ready), 32'd0);
         chk("s3_busy_exec", 32'(busy3), 32'd1);
         @(posedge clk);
         #1;
         lat++;
      end
      chk("s3_latency", 32'(lat), 32'd3);
      for (int k = 0; k < 5; k++) begin
         chk("s3_hold_valid", 32'(r3_valid), 32'd1);
         chk("s3_hold_data", r3_data, 32'd123);
         chk("s3_hold_zero", 32'(r3_zero), 32'd0);
         chk("s3_hold_ready", 32'(c3_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      r3_ready = 1'b1; c3_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("s3_valid_drop", 32'(r3_valid), 32'd0);
      chk("s3_cmd_ready_back", 32'(c3_ready), 32'd1);
      chk("s3_busy_clear", 32'(busy3), 32'd0);
      chk("s3_no_second_accept_rs", a3_rs, 32'd100);
      chk("s3_no_second_accept_op", 32'(a3_op), 32'd0);

      // Reset during EXEC: command discarded, no response
      send1(6'h20, 32'd1, 32'd2);
      chk("rx_busy_before", 32'(busy1), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rx_busy", 32'(busy1), 32'd0);
      chk("rx_cmd_ready", 32'(c1_ready), 32'd1);
      chk("rx_alu_opcode", 32'(a1_op), 32'(ILL));
      chk("rx_alu_rs", a1_rs, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rx_no_rsp", 32'(r1_valid), 32'd0);

      // Reset during RESP: pending response dropped
      r1_ready = 1'b0;
      send1(6'h18, 32'd3, 32'd5);
      wait_valid1(lat);
      chk("rr_valid_before", 32'(r1_valid), 32'd1);
      chk("rr_data_before", r1_data, 32'd15);
      rst_n = 1'b0;
      #1;
      chk("rr_valid", 32'(r1_valid), 32'd0);
      chk("rr_data", r1_data, 32'd0);
      chk("rr_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      r1_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rr_no_rsp", 32'(r1_valid), 32'd0);

      // Next command after reset completes normally
      sb.push_back('{32'd0, 1'b1, 1'b0});
      send1(6'h22, 32'd20, 32'd20);
      chk("post_alu_opcode", 32'(a1_op), 32'd1);
      wait_valid1(lat);
      chk("post_latency", 32'(lat), 32'd1);

      lat = 0;
      while (sb.size() != 0 && lat < 50) begin
         @(posedge clk);
         lat++;
      end
      repeat (2) @(posedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
